// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the 7-segment scanner.
package seven_seg_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_A   = 7'h08;
    localparam logic [6:0] SEG_B   = 7'h03;
    localparam logic [6:0] SEG_C   = 7'h46;
    localparam logic [6:0] SEG_D   = 7'h21;
    localparam logic [6:0] SEG_E   = 7'h06;
    localparam logic [6:0] SEG_F   = 7'h0E;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Bits needed to hold 0..value-1, never less than 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((32'd1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Display bus between the time formatter (master) and the scanner (slave).
interface seven_seg_scanner_if #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned BRIGHT_W   = 4
);
    localparam int unsigned IDX_W = seven_seg_pkg::clog2(NUM_DIGITS);

    logic                    en;
    logic [4*NUM_DIGITS-1:0] digit_data;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [BRIGHT_W-1:0]     brightness;
    logic [NUM_DIGITS-1:0]   AN;
    logic [6:0]              SEG;
    logic                    DP;
    logic [IDX_W-1:0]        digit_idx;

    modport master (
        output en, digit_data, dp_in, blank_mask, brightness,
        input  AN, SEG, DP, digit_idx
    );

    modport slave (
        input  en, digit_data, dp_in, blank_mask, brightness,
        output AN, SEG, DP, digit_idx
    );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment decode.
module hex_to_seg7
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Nibble lookup into the shared glyph table.
    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            default: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode 7-segment scanner with blanking, decimal
// points, PWM brightness and a one-cycle anti-ghost dead time per slot.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned BRIGHT_W   = 4
) (
    input logic               clk,
    input logic               reset,
    seven_seg_scanner_if.slave bus
);

    localparam int unsigned IDX_W     = clog2(NUM_DIGITS);
    localparam int unsigned CNT_W     = clog2(SCAN_DIV);
    localparam int unsigned PHASES    = 32'd1 << BRIGHT_W;
    localparam int unsigned PHASE_LEN = SCAN_DIV / PHASES;
    localparam int unsigned SUB_W     = clog2(PHASE_LEN);

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(PHASE_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      pre_q, pre_d;
    logic [SUB_W-1:0]      sub_q, sub_d;
    logic [BRIGHT_W-1:0]   phase_q, phase_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [3:0]            nib_q;
    logic                  dp_q;
    logic                  blank_q;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_out_q, dp_out_d;
    logic [6:0]            seg_dec;
    logic                  slot_start;
    logic                  lit;

    assign slot_start = (pre_q == '0);

    hex_to_seg7 u_dec (
        .nibble (nib_q),
        .seg    (seg_dec)
    );

    // Prescaler, PWM phase sub-counter and digit index advance.
    // The phase counter wraps with the prescaler since SCAN_DIV is a multiple of PHASES.
    always_comb begin
        pre_d   = pre_q;
        sub_d   = sub_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        if (pre_q == PRE_LAST) begin
            pre_d   = '0;
            sub_d   = '0;
            phase_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            pre_d = pre_q + 1'b1;
            if (sub_q == SUB_LAST) begin
                sub_d   = '0;
                phase_d = phase_q + 1'b1;
            end else begin
                sub_d = sub_q + 1'b1;
            end
        end
    end

    // Output gating; slot cycle 0 is dead so the stale snapshot is never shown.
    always_comb begin
        lit      = bus.en && !blank_q && (phase_q < bus.brightness) && !slot_start;
        an_d     = '1;
        seg_d    = SEG_OFF;
        dp_out_d = 1'b1;
        if (lit) begin
            an_d[idx_q] = 1'b0;
            seg_d       = seg_dec;
            dp_out_d    = ~dp_q;
        end
    end

    // Counter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q   <= '0;
            sub_q   <= '0;
            phase_q <= '0;
            idx_q   <= '0;
        end else begin
            pre_q   <= pre_d;
            sub_q   <= sub_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
        end
    end

    // Per-slot snapshot so mid-slot input changes cannot tear the display.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nib_q   <= '0;
            dp_q    <= 1'b0;
            blank_q <= 1'b0;
        end else if (slot_start) begin
            nib_q   <= bus.digit_data[{idx_q, 2'b00} +: 4];
            dp_q    <= bus.dp_in[idx_q];
            blank_q <= bus.blank_mask[idx_q];
        end
    end

    // Registered pin drivers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_q     <= '1;
            seg_q    <= SEG_OFF;
            dp_out_q <= 1'b1;
        end else begin
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_out_q <= dp_out_d;
        end
    end

    assign bus.AN        = an_q;
    assign bus.SEG       = seg_q;
    assign bus.DP        = dp_out_q;
    assign bus.digit_idx = idx_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: a cycle model pushes expected pin values to a
// scoreboard queue, a monitor pops and compares them, and directed steps check
// scan order, brightness, blanking, snapshot and reset/enable behaviour.
module tb_seven_seg_scanner;

    localparam int N   = 8;
    localparam int DIV = 16;
    localparam int BW  = 2;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [2:0] idx;
    } out_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int lit_tab [4] = '{0, 3, 7, 11};

    out_t exp_q [$];

    always #5 clk = ~clk;

    seven_seg_scanner_if #(.NUM_DIGITS(N), .BRIGHT_W(BW)) bus ();

    seven_seg_scanner #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (DIV),
        .BRIGHT_W   (BW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected registered outputs for each clock edge.
    int         m_pre = 0;
    int         m_idx = 0;
    logic [3:0] m_nib = 4'h0;
    logic       m_dp = 1'b0;
    logic       m_blank = 1'b0;
    out_t       m_e;
    int         m_ph;
    bit         m_lit;

    always @(posedge clk) begin
        if (reset) begin
            m_pre = 0;
            m_idx = 0;
            m_nib = 4'h0;
            m_dp = 1'b0;
            m_blank = 1'b0;
            exp_q.delete();
        end else begin
            m_ph  = m_pre / (DIV >> BW);
            m_lit = bus.en && !m_blank && (m_ph < int'(bus.brightness)) && (m_pre != 0);
            m_e.an  = 8'hFF;
            m_e.seg = 7'h7F;
            m_e.dp  = 1'b1;
            if (m_lit) begin
                m_e.an  = ~(8'h01 << m_idx);
                m_e.seg = seg_tab[m_nib];
                m_e.dp  = ~m_dp;
            end
            if (m_pre == 0) begin
                m_nib   = bus.digit_data[4*m_idx +: 4];
                m_dp    = bus.dp_in[m_idx];
                m_blank = bus.blank_mask[m_idx];
            end
            if (m_pre == DIV - 1) begin
                m_pre = 0;
                m_idx = (m_idx + 1) % N;
            end else begin
                m_pre++;
            end
            m_e.idx = 3'(m_idx);
            exp_q.push_back(m_e);
        end
    end

    // Monitor: compare each cycle against the scoreboard, just after the edge.
    out_t mon_e;
    always @(posedge clk) begin
        #1;
        check("onehot", 32'($countones(~bus.AN) <= 1), 32'd1);
        if (reset) begin
            check("rst_an", bus.AN, 8'hFF);
            check("rst_seg", bus.SEG, 7'h7F);
            check("rst_dp", bus.DP, 1'b1);
            check("rst_idx", bus.digit_idx, 3'd0);
        end else if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("scoreboard", {bus.AN, bus.SEG, bus.DP, bus.digit_idx}, mon_e);
        end
    end

    task automatic wait_lit(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.AN !== 8'hFF) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_an(input logic [7:0] v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.AN === v) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic count_window(input int cycles, output int lit, output int dplow,
                                output int an_fb, output int dp_bad);
        lit = 0; dplow = 0; an_fb = 0; dp_bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.AN !== 8'hFF) lit++;
            if (bus.DP === 1'b0) dplow++;
            if (bus.AN === 8'hFB) an_fb++;
            if (bus.DP === 1'b0 && bus.AN !== 8'hFE) dp_bad++;
        end
    endtask

    initial begin
        bit         ok;
        int         lit, dplow, an_fb, dp_bad;
        logic [7:0] exp_an;
        logic [2:0] idx0;

        bus.en         = 1'b1;
        bus.digit_data = 32'h76543210;
        bus.dp_in      = 8'h00;
        bus.blank_mask = 8'h00;
        bus.brightness = 2'd3;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Scan order FE..7F and wrap, with digit glyphs 0..7.
        for (int k = 0; k < 9; k++) begin
            wait_lit(ok);
            check("scan_lit_timeout", 32'(ok), 32'd1);
            exp_an = ~(8'h01 << (k % 8));
            check("scan_an", bus.AN, exp_an);
            check("scan_seg", bus.SEG, seg_tab[k % 8]);
            wait_an(8'hFF, ok);
            check("scan_dark_timeout", 32'(ok), 32'd1);
        end

        // Brightness sweep over 8 whole slots per setting.
        for (int b = 0; b < 4; b++) begin
            bus.brightness = 2'(b);
            repeat (20) @(negedge clk);
            count_window(N * DIV, lit, dplow, an_fb, dp_bad);
            check("bright_lit", lit, 8 * lit_tab[b]);
        end

        // Blanked digit 2, decimal point on digit 0.
        bus.blank_mask = 8'h04;
        bus.dp_in      = 8'h01;
        repeat (20) @(negedge clk);
        count_window(N * DIV, lit, dplow, an_fb, dp_bad);
        check("blank_lit", lit, 77);
        check("blank_an_fb", an_fb, 0);
        check("dp_low_cycles", dplow, 11);
        check("dp_only_digit0", dp_bad, 0);
        bus.blank_mask = 8'h00;
        bus.dp_in      = 8'h00;

        // Mid-slot nibble change must wait for the next digit-0 slot.
        wait_an(8'hFE, ok);
        check("mid_wait0", 32'(ok), 32'd1);
        repeat (4) @(negedge clk);
        bus.digit_data[3:0] = 4'h8;
        for (int i = 0; i < 16 && bus.AN === 8'hFE; i++) begin
            check("mid_seg_hold", bus.SEG, 7'h40);
            @(negedge clk);
        end
        wait_an(8'hFE, ok);
        check("mid_wait1", 32'(ok), 32'd1);
        check("mid_seg_new", bus.SEG, 7'h00);

        // Enable drop: anodes off next cycle, scan keeps counting.
        wait_lit(ok);
        check("en_lit_timeout", 32'(ok), 32'd1);
        bus.en = 1'b0;
        idx0 = bus.digit_idx;
        @(negedge clk);
        check("en_off_an", bus.AN, 8'hFF);
        repeat (DIV - 1) @(negedge clk);
        check("en_idx_runs", bus.digit_idx, 3'(idx0 + 3'd1));
        bus.en = 1'b1;

        // Async reset mid-slot.
        wait_an(8'hF7, ok);
        check("rst_wait", 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("arst_an", bus.AN, 8'hFF);
        check("arst_seg", bus.SEG, 7'h7F);
        check("arst_dp", bus.DP, 1'b1);
        check("arst_idx", bus.digit_idx, 3'd0);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        wait_lit(ok);
        check("arst_first_lit", 32'(ok), 32'd1);
        check("arst_first_digit", bus.AN, 8'hFE);

        // Random soak; scoreboard and one-hot check run every cycle.
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (reset) begin
                reset = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            end else if ($urandom_range(0, 499) == 0) begin
                reset = 1'b1;
            end
            bus.en = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 7) == 0) bus.brightness = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) bus.digit_data = $urandom;
            if ($urandom_range(0, 9) == 0) bus.dp_in = 8'($urandom);
            if ($urandom_range(0, 9) == 0) bus.blank_mask = 8'($urandom & $urandom);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
